// File: rtl/alu_seq_if.sv
// alu_seq_if: valid/ready operand and result bundle for alu_seq
// master: drives in_valid/a/b/op/out_ready and observes in_ready, out_valid, result and flags
// slave: the ALU side of the same signals
interface alu_seq_if #(parameter int WIDTH = 8);
  logic in_valid, in_ready, out_valid, out_ready;
  logic carry, zero, neg, ovf, err;
  logic [WIDTH-1:0] a, b, result;
  logic [2:0] op;
  modport master(output in_valid, a, b, op, out_ready,
                 input in_ready, out_valid, result, carry, zero, neg, ovf, err);
  modport slave(input in_valid, a, b, op, out_ready,
                output in_ready, out_valid, result, carry, zero, neg, ovf, err);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked WIDTH-bit ALU with registered result/flags and optional iterative multiply
// ports: clk, rst (sync, active-high), bus (alu_seq_if.slave: in_valid/in_ready/a/b/op in,
//        out_valid/out_ready/result/carry/zero/neg/ovf/err out)
// ALU_MUL_EN: when defined, op 111 is a WIDTH-cycle shift-add multiply; otherwise it flags err
module alu_seq #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  alu_seq_if.slave bus
);
  localparam int SW = $clog2(WIDTH);
  logic [WIDTH:0] sum, diff, shl, shr;
  logic [SW-1:0] amt;
  logic [WIDTH-1:0] alu_res;
  logic alu_c, alu_v, alu_e;
  logic in_fire, out_fire, idle;
  assign amt = bus.b[SW-1:0];
  assign sum = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff = {1'b0, bus.a} - {1'b0, bus.b};
  // the extra bit on each side catches the last bit shifted out
  assign shl = {1'b0, bus.a} << amt;
  assign shr = {bus.a, 1'b0} >> amt;
  assign in_fire = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;
  assign bus.in_ready = idle && (!bus.out_valid || bus.out_ready);
  always_comb begin
    alu_res = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    alu_e = 1'b0;
    case (bus.op)
      3'd0: begin
        alu_res = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      3'd1: begin
        alu_res = diff[WIDTH-1:0];
        alu_c = diff[WIDTH];
        alu_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      3'd2: alu_res = bus.a & bus.b;
      3'd3: alu_res = bus.a | bus.b;
      3'd4: alu_res = bus.a ^ bus.b;
      3'd5: {alu_c, alu_res} = shl;
      3'd6: {alu_res, alu_c} = shr;
`ifdef ALU_MUL_EN
      default: alu_e = 1'b0;
`else
      default: alu_e = 1'b1;
`endif
    endcase
  end
`ifdef ALU_MUL_EN
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] cnt_q;
  logic [2*WIDTH-1:0] acc_q, mcand_q, acc_step;
  logic [WIDTH-1:0] mplier_q;
  logic mul_start, mul_done;
  assign idle = state_q == IDLE;
  assign mul_start = in_fire && bus.op == 3'b111;
  assign mul_done = state_q == BUSY && cnt_q == SW'(WIDTH - 1);
  // one partial product per step; the final step feeds the output register directly
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  always_comb begin
    state_d = state_q;
    state_d = mul_start ? BUSY : mul_done ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
    end else begin
      state_q <= state_d;
      if (mul_start) begin
        cnt_q <= '0;
        acc_q <= '0;
        mcand_q <= {{WIDTH{1'b0}}, bus.a};
        mplier_q <= bus.b;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + 1'b1;
        acc_q <= acc_step;
        mcand_q <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
      end
    end
  end
`else
  assign idle = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.result <= '0;
      bus.carry <= 1'b0;
      bus.zero <= 1'b0;
      bus.neg <= 1'b0;
      bus.ovf <= 1'b0;
      bus.err <= 1'b0;
    end
`ifdef ALU_MUL_EN
    else if (mul_done) begin
      bus.out_valid <= 1'b1;
      bus.result <= acc_step[WIDTH-1:0];
      bus.carry <= |acc_step[2*WIDTH-1:WIDTH];
      bus.zero <= acc_step[WIDTH-1:0] == '0;
      bus.neg <= acc_step[WIDTH-1];
      bus.ovf <= 1'b0;
      bus.err <= 1'b0;
    end else if (mul_start) begin
      bus.out_valid <= 1'b0;
    end
`endif
    else if (in_fire) begin
      bus.out_valid <= 1'b1;
      bus.result <= alu_res;
      bus.carry <= alu_c;
      bus.zero <= alu_res == '0;
      bus.neg <= alu_res[WIDTH-1];
      bus.ovf <= alu_v;
      bus.err <= alu_e;
    end else if (out_fire) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq with directed corner cases and random traffic
module tb_alu_seq;
  localparam int W = 8;
  typedef struct {
    logic [W-1:0] r;
    logic c, z, n, v, er;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bit rnd_bp = 1'b0;
  int tests = 0;
  int fails = 0;
  exp_t q[$];
  alu_seq_if #(.WIDTH(W)) bus();
  alu_seq #(.WIDTH(W)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint ua = longint'(x);
    longint ub = longint'(y);
    longint m = longint'(1) << W;
    longint sa = x[W-1] ? ua - m : ua;
    longint sb = y[W-1] ? ub - m : ub;
    longint p;
    int amt = int'(ub % W);
    exp_t e;
    e = '{default: '0};
    case (o)
      3'd0: begin
        p = ua + ub; e.r = W'(p); e.c = p >= m;
        p = sa + sb; e.v = p >= m / 2 || p < -(m / 2);
      end
      3'd1: begin
        p = ua - ub; e.r = W'(p); e.c = ua < ub;
        p = sa - sb; e.v = p >= m / 2 || p < -(m / 2);
      end
      3'd2: e.r = x & y;
      3'd3: e.r = x | y;
      3'd4: e.r = x ^ y;
      3'd5: begin
        e.r = W'(ua << amt);
        e.c = amt != 0 && ((ua >> (W - amt)) & 1) != 0;
      end
      3'd6: begin
        e.r = W'(ua >> amt);
        e.c = amt != 0 && ((ua >> (amt - 1)) & 1) != 0;
      end
      default: begin
`ifdef ALU_MUL_EN
        p = ua * ub; e.r = W'(p); e.c = p >= m;
`else
        e.r = '0; e.er = 1'b1;
`endif
      end
    endcase
    e.z = e.r == '0;
    e.n = e.r[W-1];
    return e;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    bit ok = 1'b0;
    bus.in_valid = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    for (int n = 0; n < 100 && !ok; n++) begin
      if (rnd_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      ok = bus.in_ready;
      if (ok) q.push_back(model(o, x, y));
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'(ok), 32'd1);
  endtask
  task automatic drain();
    for (int i = 0; i < 400 && q.size() != 0; i++) begin
      if (rnd_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: got result %0h with no pending op", bus.result);
        end else begin
          e = q.pop_front();
          if ({bus.result, bus.carry, bus.zero, bus.neg, bus.ovf, bus.err} !== {e.r, e.c, e.z, e.n, e.v, e.er}) begin
            fails++;
            $display("FAIL sb_out: got r=%h c%b z%b n%b v%b e%b expected r=%h c%b z%b n%b v%b e%b",
                     bus.result, bus.carry, bus.zero, bus.neg, bus.ovf, bus.err, e.r, e.c, e.z, e.n, e.v, e.er);
          end
        end
      end
    end
  endtask
  initial begin
    int k;
    bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
    fork
      monitor();
      begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_flags", 32'({bus.carry, bus.zero, bus.neg, bus.ovf, bus.err}), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        issue(3'd0, 8'hF0, 8'h20);
        chk("add_f0_20", 32'({bus.result, bus.carry, bus.ovf}), 32'({8'h10, 2'b10}));
        issue(3'd0, 8'h7F, 8'h01);
        chk("add_7f_01", 32'({bus.result, bus.neg, bus.ovf, bus.carry}), 32'({8'h80, 3'b110}));
        issue(3'd1, 8'h05, 8'h05);
        chk("sub_5_5", 32'({bus.result, bus.zero, bus.carry}), 32'({8'h00, 2'b10}));
        issue(3'd1, 8'h03, 8'h05);
        chk("sub_3_5", 32'({bus.result, bus.carry, bus.neg, bus.ovf}), 32'({8'hFE, 3'b110}));
        issue(3'd5, 8'h81, 8'h09);
        chk("shl_81_1", 32'({bus.result, bus.carry}), 32'({8'h02, 1'b1}));
        issue(3'd6, 8'h01, 8'h00);
        chk("shr_01_0", 32'({bus.result, bus.carry}), 32'({8'h01, 1'b0}));
`ifdef ALU_MUL_EN
        issue(3'd7, 8'h0F, 8'h11);
        chk("mul_busy_in_ready", 32'(bus.in_ready), 32'd0);
        k = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
          @(posedge clk); #1;
          if (bus.out_valid) k = i;
        end
        chk("mul_latency", 32'(k), 32'(W));
        chk("mul_0f_11", 32'({bus.result, bus.carry}), 32'({8'hFF, 1'b0}));
        issue(3'd7, 8'h10, 8'h10);
        repeat (W) begin @(posedge clk); #1; end
        chk("mul_10_10", 32'({bus.out_valid, bus.result, bus.carry, bus.zero}), 32'({1'b1, 8'h00, 2'b11}));
`else
        issue(3'd7, 8'h12, 8'h34);
        chk("mul_off_err", 32'({bus.out_valid, bus.result, bus.zero, bus.err, bus.carry}), 32'({1'b1, 8'h00, 3'b110}));
`endif
        drain();
        bus.out_ready = 1'b0;
        issue(3'd0, 8'h11, 8'h22);
        bus.in_valid = 1'b1; bus.op = 3'd0; bus.a = 8'h40; bus.b = 8'h40;
        repeat (3) begin
          chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
          chk("bp_hold", 32'({bus.out_valid, bus.result, bus.carry, bus.ovf}), 32'({1'b1, 8'h33, 2'b00}));
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
        q.push_back(model(3'd0, 8'h40, 8'h40));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp_new_result", 32'({bus.out_valid, bus.result, bus.ovf, bus.neg}), 32'({1'b1, 8'h80, 2'b11}));
        drain();
`ifdef ALU_MUL_EN
        issue(3'd7, 8'h0F, 8'h11);
`else
        bus.out_ready = 1'b0;
        issue(3'd0, 8'hFF, 8'h01);
`endif
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(q.pop_back());
        bus.out_ready = 1'b1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_flags", 32'({bus.result, bus.carry, bus.zero, bus.neg, bus.ovf, bus.err}), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (12) begin @(posedge clk); #1; end
        chk("mid_rst_no_result", 32'(bus.out_valid), 32'd0);
        rnd_bp = 1'b1;
        for (int i = 0; i < 200; i++) issue(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
        drain();
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the team's 8-bit, 4-op ALU. Accepts one operation per transfer on a valid/ready input port. Produces a registered result plus carry/zero/negative/overflow flags on a valid/ready output port. Sits between the CPU decode stage and register writeback. Single-cycle logic ops and an optional iterative multi-cycle multiply share one output register.

## Interface
- `WIDTH`, default 8: operand/result width; legal values 8, 16, 32.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: operand/op presented.
- `in_ready`, output, 1: block can accept this cycle.
- `a`, input, WIDTH: operand A.
- `b`, input, WIDTH: operand B.
- `op`, input, 3: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
- `out_valid`, output, 1: result/flags valid.
- `out_ready`, input, 1: consumer takes result.
- `result`, output, WIDTH: registered result.
- `carry`, output, 1: carry/borrow/shifted-out bit/multiply overflow.
- `zero`, output, 1: result == 0.
- `neg`, output, 1: result[WIDTH-1].
- `ovf`, output, 1: signed overflow (ADD/SUB only).
- `err`, output, 1: unsupported op executed.

## Operation
- **Transfer rules**
  - Input transfer occurs when `in_valid && in_ready` at a rising edge.
  - Output transfer occurs when `out_valid && out_ready`.
  - `in_ready = (state==IDLE) && (!out_valid || out_ready)`. This is combinational from `out_ready`.
- **States:** IDLE and BUSY.
  - IDLE→BUSY on accepted MUL.
  - BUSY→IDLE after WIDTH steps.
  - Non-MUL ops never leave IDLE.
- **Result and flag rules**
  - All results are truncated to WIDTH.
  - `zero` and `neg` are computed from the truncated result for every op.
- **ADD:** result is `a+b`; `carry` = bit WIDTH of the (WIDTH+1)-bit sum; `ovf` = signed overflow.
- **SUB:** result is `a-b`; `carry` = borrow (`a<b` unsigned); `ovf` = signed overflow.
- **AND/OR/XOR:** `carry=0`, `ovf=0`.
- **SHL/SHR (logical)**
  - Shift amount is `b[$clog2(WIDTH)-1:0]`.
  - `carry` = last bit shifted out; `carry=0` when the amount is 0.
  - `ovf=0`.
- **MUL (unsigned shift-add)**
  - One partial product per cycle.
  - `result` = low WIDTH bits of the product.
  - `carry` = OR of the high WIDTH bits.
  - `ovf=0`.
- **Output register**
  - Holds `result` and all flags stable while `out_valid && !out_ready`.
  - `out_valid` clears on an output transfer unless a new input transfer occurs on the same edge.
- **err:** set only by op 111 when `ALU_MUL_EN` is undefined; otherwise 0.
- **Reset values**
  - State IDLE; `out_valid=0`; `result=0`; `carry=zero=neg=ovf=err=0`; MUL counter 0.
  - `in_ready` is 1 in the cycle after reset deasserts.

## Timing
- **Single-cycle ops:** accepted at edge N; `out_valid` and result are visible after edge N. Throughput is 1/cycle while `out_ready=1`.
- **MUL:** accepted at edge N; steps run at edges N+1..N+WIDTH.
  - `out_valid` and result are visible after edge N+WIDTH.
  - `in_ready=0` from after edge N until the BUSY→IDLE transition.
- **Simultaneous output and input transfer on one edge:** the new result replaces the old one and `out_valid` stays 1.
- **MUL accepted while an old result is being consumed:** the old result transfers; `out_valid` falls after that edge and stays 0 until MUL completes.
- **`rst` mid-MUL:** aborts the multiply, returns to IDLE with reset values, and produces no result. `rst` has priority over all transfers.
- **`in_valid` while `in_ready=0`:** ignored. Operands need not be held by the block.

## Configuration
- **`ALU_MUL_EN` defined**
  - Compiles in the BUSY state, counter and shift-add datapath.
  - MUL behaves as specified above.
- **`ALU_MUL_EN` undefined**
  - No BUSY state; all ops are single-cycle.
  - Op 111 yields `result=0`, `zero=1`, `carry=neg=ovf=0`, `err=1` with latency 1.

## Test plan
- **ADD** (WIDTH=8): ADD 0xF0+0x20 → result 0x10, carry=1, ovf=0. ADD 0x7F+0x01 → 0x80, neg=1, ovf=1, carry=0.
- **SUB:** SUB 0x05-0x05 → 0x00, zero=1, carry=0. SUB 0x03-0x05 → 0xFE, carry=1, neg=1, ovf=0.
- **Shift:** SHL 0x81 by b=0x09 (amount 1) → 0x02, carry=1. SHR 0x01 by 0 → 0x01, carry=0.
- **MUL** (macro on): 0x0F*0x11 → 0xFF, carry=0, `out_valid` exactly 8 edges after accept. 0x10*0x10 → 0x00, carry=1, zero=1. Macro off: op 111 → err=1 after 1 edge.
- **Backpressure:** back-to-back ADDs with `out_ready=0` for 3 cycles.
  - result and flags hold; `in_ready=0`.
  - On `out_ready=1`, the old result transfers and the next op is accepted on the same edge.
- **Reset during MUL:** assert `rst` 3 edges after a MUL accept → `out_valid=0`, all flags 0, `in_ready=1` next cycle, no result emitted.
